// File: rtl/window_3x3_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_gen_if
// Description : Pixel-stream / window bus for the 3x3 neighbourhood generator.
//               The master drives the raster pixel stream and receives the
//               nine-pixel window; the slave (window_3x3_gen) does the reverse.
// Signals     : in_valid   - in_pixel valid this cycle
//               in_sof     - with in_valid: pixel is frame position (0,0)
//               in_pixel   - raster-order pixel, DATA_W bits
//               win1..win9 - window, rows r-2 / r-1 / r, columns c-2 .. c
//               out_valid  - one-cycle pulse per window
//               frame_done - one-cycle pulse with the last window of a frame
// Revision    : 1.0 - initial release
// ============================================================================
interface window_3x3_gen_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_pixel;
  logic [DATA_W-1:0] win1;
  logic [DATA_W-1:0] win2;
  logic [DATA_W-1:0] win3;
  logic [DATA_W-1:0] win4;
  logic [DATA_W-1:0] win5;
  logic [DATA_W-1:0] win6;
  logic [DATA_W-1:0] win7;
  logic [DATA_W-1:0] win8;
  logic [DATA_W-1:0] win9;
  logic              out_valid;
  logic              frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  win1, win2, win3, win4, win5, win6, win7, win8, win9,
    input  out_valid, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output win1, win2, win3, win4, win5, win6, win7, win8, win9,
    output out_valid, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_gen
// Description : Streaming 3x3 neighbourhood generator. Accepts one raster
//               pixel per valid cycle, keeps the two previous rows in line
//               buffers and presents a registered 3x3 window for every fully
//               interior position, one clock after the pixel that completes it.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - window_3x3_gen_if.slave (pixel stream in, window out)
// Parameters  : IMG_WIDTH  - pixels per line (>= 3)
//               IMG_HEIGHT - lines per frame (>= 3)
//               DATA_W     - pixel width, must match the interface DATA_W
// Revision    : 1.0 - initial release
// ============================================================================
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  window_3x3_gen_if.slave bus
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] c_COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] c_ROW_TWO  = ROW_W'(2);

  // Position counters and registered outputs
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] win_q [9];

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2. No reset; their
  // contents only reach the outputs after two fresh rows have been written.
  logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb2_q [IMG_WIDTH];

  logic              accept_w;
  logic [COL_W-1:0]  eff_col_w;
  logic [ROW_W-1:0]  eff_row_w;
  logic [DATA_W-1:0] lb1_rd_w;
  logic [DATA_W-1:0] lb2_rd_w;

  assign accept_w  = bus.in_valid && !rst;

  // A start-of-frame pixel is position (0,0) whatever the counters say.
  assign eff_col_w = bus.in_sof ? '0 : col_q;
  assign eff_row_w = bus.in_sof ? '0 : row_q;

  // Asynchronous reads give the old contents in the same cycle that the
  // write below replaces them (read-before-write at one address).
  assign lb1_rd_w  = lb1_q[eff_col_w];
  assign lb2_rd_w  = lb2_q[eff_col_w];

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept_w) begin
      if (eff_col_w == c_COL_LAST) begin
        col_d = '0;
        row_d = (eff_row_w == c_ROW_LAST) ? '0 : eff_row_w + 1'b1;
      end else begin
        col_d = eff_col_w + 1'b1;
        row_d = eff_row_w;
      end
      // col >= 2 keeps every window inside a single line.
      out_valid_d  = (eff_row_w >= c_ROW_TWO) && (eff_col_w >= c_COL_TWO);
      frame_done_d = (eff_row_w == c_ROW_LAST) && (eff_col_w == c_COL_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (accept_w) begin
      lb2_q[eff_col_w] <= lb1_rd_w;
      lb1_q[eff_col_w] <= bus.in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      if (accept_w) begin
        // Each window row shifts left; the new right column is the
        // current column of rows r-2, r-1 and r.
        for (int r = 0; r < 3; r++) begin
          win_q[3*r]   <= win_q[3*r+1];
          win_q[3*r+1] <= win_q[3*r+2];
        end
        win_q[2] <= lb2_rd_w;
        win_q[5] <= lb1_rd_w;
        win_q[8] <= bus.in_pixel;
      end
    end
  end

  assign bus.win1       = win_q[0];
  assign bus.win2       = win_q[1];
  assign bus.win3       = win_q[2];
  assign bus.win4       = win_q[3];
  assign bus.win5       = win_q[4];
  assign bus.win6       = win_q[5];
  assign bus.win7       = win_q[6];
  assign bus.win8       = win_q[7];
  assign bus.win9       = win_q[8];
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_3x3_gen
// Description : Directed self-checking bench for window_3x3_gen on an 8x6
//               image. Pixel values are base + row*8 + col, so every expected
//               window follows directly from its position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_3x3_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  window_3x3_gen_if #(.DATA_W(8)) bus ();

  window_3x3_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [71:0] win_flat;
  assign win_flat = {bus.win1, bus.win2, bus.win3, bus.win4, bus.win5,
                     bus.win6, bus.win7, bus.win8, bus.win9};

  function automatic logic [7:0] pix(input int base, input int r, input int c);
    return 8'(base + r*W + c);
  endfunction

  // Window completed by the pixel at (r,c): rows r-2..r, columns c-2..c.
  function automatic logic [71:0] exp_win(input int base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int j = 0; j < 9; j++) begin
      w[(8-j)*8 +: 8] = 8'(base + (r - 2 + j/3)*W + (c - 2 + j%3));
    end
    return w;
  endfunction

  // Drive one cycle of stimulus; outputs are observed 1 time unit after the edge.
  task automatic step(input logic v, input logic s, input logic [7:0] p);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'hA5);
      n_vec++;
      if ({bus.out_valid, bus.frame_done, win_flat} !== 74'd0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: got v=%b fd=%b win=%h, want all 0",
                 i, bus.out_valid, bus.frame_done, win_flat);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i[0], 8'h5A);
      n_vec++;
      if ({bus.out_valid, bus.frame_done, win_flat} !== 74'd0) begin
        n_err++;
        $display("FAIL idle_after_reset cyc%0d: got v=%b fd=%b win=%h, want all 0",
                 i, bus.out_valid, bus.frame_done, win_flat);
      end
    end
  endtask

  task automatic test_continuous();
    int nwin;
    nwin = 0;
    for (int k = 0; k < W*H; k++) begin
      automatic int r = k / W;
      automatic int c = k % W;
      step(1'b1, k == 0, pix(0, r, c));
      n_vec++;
      if ({bus.out_valid, bus.frame_done} !== {(r >= 2) && (c >= 2), k == W*H-1}) begin
        n_err++;
        $display("FAIL cont_strobes k=%0d: got v=%b fd=%b, want v=%b fd=%b",
                 k, bus.out_valid, bus.frame_done, (r >= 2) && (c >= 2), k == W*H-1);
      end
      if (bus.out_valid) nwin++;
      if ((r >= 2) && (c >= 2)) begin
        n_vec++;
        if (win_flat !== exp_win(0, r, c)) begin
          n_err++;
          $display("FAIL cont_window (%0d,%0d): got %h, want %h", r, c, win_flat, exp_win(0, r, c));
        end
      end
      if (k == 18) begin
        n_vec++;
        if (win_flat !== 72'h00_01_02_08_09_0A_10_11_12) begin
          n_err++;
          $display("FAIL cont_first_window: got %h, want 00010208090a101112", win_flat);
        end
      end
      if (k == W*H-1) begin
        n_vec++;
        if (win_flat !== 72'h1D_1E_1F_25_26_27_2D_2E_2F) begin
          n_err++;
          $display("FAIL cont_last_window: got %h, want 1d1e1f2526272d2e2f", win_flat);
        end
      end
    end
    n_vec++;
    if (nwin !== 24) begin
      n_err++;
      $display("FAIL cont_window_count: got %0d, want 24", nwin);
    end
  endtask

  task automatic test_gaps();
    int          nwin;
    logic        had_win;
    logic [71:0] last_win;
    nwin     = 0;
    had_win  = 1'b0;
    last_win = '0;
    for (int k = 0; k < W*H; k++) begin
      automatic int r    = k / W;
      automatic int c    = k % W;
      automatic int gaps = 0;
      while (($urandom_range(0, 1) == 0) && (gaps < 4)) begin
        // in_sof without in_valid must be ignored
        step(1'b0, 1'b1, 8'hEE);
        gaps++;
        n_vec++;
        if ({bus.out_valid, bus.frame_done} !== 2'b00) begin
          n_err++;
          $display("FAIL gap_strobes k=%0d: got v=%b fd=%b, want 0 0",
                   k, bus.out_valid, bus.frame_done);
        end
        if (had_win) begin
          n_vec++;
          if (win_flat !== last_win) begin
            n_err++;
            $display("FAIL gap_hold k=%0d: got %h, want %h", k, win_flat, last_win);
          end
        end
      end
      step(1'b1, k == 0, pix(0, r, c));
      had_win = (r >= 2) && (c >= 2);
      n_vec++;
      if ({bus.out_valid, bus.frame_done} !== {(r >= 2) && (c >= 2), k == W*H-1}) begin
        n_err++;
        $display("FAIL gap_pixel_strobes k=%0d: got v=%b fd=%b, want v=%b fd=%b",
                 k, bus.out_valid, bus.frame_done, (r >= 2) && (c >= 2), k == W*H-1);
      end
      if (bus.out_valid) nwin++;
      if (had_win) begin
        last_win = exp_win(0, r, c);
        n_vec++;
        if (win_flat !== last_win) begin
          n_err++;
          $display("FAIL gap_window (%0d,%0d): got %h, want %h", r, c, win_flat, last_win);
        end
      end
    end
    n_vec++;
    if (nwin !== 24) begin
      n_err++;
      $display("FAIL gap_window_count: got %0d, want 24", nwin);
    end
  endtask

  task automatic test_mid_reset();
    int nwin;
    nwin = 0;
    for (int k = 0; k <= 20; k++) begin
      step(1'b1, k == 0, pix(0, k / W, k % W));
    end
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    rst = 1'b0;
    n_vec++;
    if ({bus.out_valid, bus.frame_done, win_flat} !== 74'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got v=%b fd=%b win=%h, want all 0",
               bus.out_valid, bus.frame_done, win_flat);
    end
    for (int k = 0; k < W*H; k++) begin
      automatic int r = k / W;
      automatic int c = k % W;
      step(1'b1, 1'b0, pix(100, r, c));
      n_vec++;
      if ({bus.out_valid, bus.frame_done} !== {(r >= 2) && (c >= 2), k == W*H-1}) begin
        n_err++;
        $display("FAIL restart_strobes k=%0d: got v=%b fd=%b, want v=%b fd=%b",
                 k, bus.out_valid, bus.frame_done, (r >= 2) && (c >= 2), k == W*H-1);
      end
      if (bus.out_valid) nwin++;
      if ((r >= 2) && (c >= 2)) begin
        n_vec++;
        if (win_flat !== exp_win(100, r, c)) begin
          n_err++;
          $display("FAIL restart_window (%0d,%0d): got %h, want %h", r, c, win_flat, exp_win(100, r, c));
        end
      end
      if (k == 18) begin
        n_vec++;
        if (win_flat !== 72'h64_65_66_6C_6D_6E_74_75_76) begin
          n_err++;
          $display("FAIL restart_first_window: got %h, want 6465666c6d6e747576", win_flat);
        end
      end
    end
    n_vec++;
    if (nwin !== 24) begin
      n_err++;
      $display("FAIL restart_window_count: got %0d, want 24", nwin);
    end
  endtask

  task automatic test_abort_sof();
    int nwin;
    int nfd;
    nwin = 0;
    nfd  = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b1, k == 0, pix(200, k / W, k % W));
    end
    for (int k = 0; k < W*H; k++) begin
      automatic int r = k / W;
      automatic int c = k % W;
      step(1'b1, k == 0, pix(50, r, c));
      n_vec++;
      if ({bus.out_valid, bus.frame_done} !== {(r >= 2) && (c >= 2), k == W*H-1}) begin
        n_err++;
        $display("FAIL abort_strobes k=%0d: got v=%b fd=%b, want v=%b fd=%b",
                 k, bus.out_valid, bus.frame_done, (r >= 2) && (c >= 2), k == W*H-1);
      end
      if (bus.out_valid) nwin++;
      if (bus.frame_done) nfd++;
      if ((r >= 2) && (c >= 2)) begin
        n_vec++;
        if (win_flat !== exp_win(50, r, c)) begin
          n_err++;
          $display("FAIL abort_window (%0d,%0d): got %h, want %h", r, c, win_flat, exp_win(50, r, c));
        end
      end
    end
    n_vec++;
    if ({nwin, nfd} !== {32'd24, 32'd1}) begin
      n_err++;
      $display("FAIL abort_counts: got windows=%0d frame_done=%0d, want 24 and 1", nwin, nfd);
    end
  endtask

  task automatic test_back_to_back();
    int nwin;
    int nfd;
    nwin = 0;
    nfd  = 0;
    for (int k = 0; k < 2*W*H; k++) begin
      automatic int f    = k / (W*H);
      automatic int kk   = k % (W*H);
      automatic int r    = kk / W;
      automatic int c    = kk % W;
      automatic int base = (f == 0) ? 0 : 150;
      step(1'b1, k == 0, pix(base, r, c));
      n_vec++;
      if ({bus.out_valid, bus.frame_done} !== {(r >= 2) && (c >= 2), kk == W*H-1}) begin
        n_err++;
        $display("FAIL b2b_strobes k=%0d: got v=%b fd=%b, want v=%b fd=%b",
                 k, bus.out_valid, bus.frame_done, (r >= 2) && (c >= 2), kk == W*H-1);
      end
      if (bus.out_valid) nwin++;
      if (bus.frame_done) nfd++;
      if ((r >= 2) && (c >= 2)) begin
        n_vec++;
        if (win_flat !== exp_win(base, r, c)) begin
          n_err++;
          $display("FAIL b2b_window f%0d (%0d,%0d): got %h, want %h",
                   f, r, c, win_flat, exp_win(base, r, c));
        end
      end
      if (k == W*H + 18) begin
        n_vec++;
        if (win_flat !== 72'h96_97_98_9E_9F_A0_A6_A7_A8) begin
          n_err++;
          $display("FAIL b2b_frame2_first_window: got %h, want 9697989e9fa0a6a7a8", win_flat);
        end
      end
    end
    n_vec++;
    if ({nwin, nfd} !== {32'd48, 32'd2}) begin
      n_err++;
      $display("FAIL b2b_counts: got windows=%0d frame_done=%0d, want 48 and 2", nwin, nfd);
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = 8'h00;
    test_reset();
    test_continuous();
    test_gaps();
    test_mid_reset();
    test_abort_sof();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
